// File: rtl/mcu_core.sv
// ============================================================================
// mcu_core : multi-cycle 8-bit LD/ST/ADD core, FETCH/EXEC/HALT sequencing
// Revision : 1.0
// ============================================================================
`default_nettype none

module mcu_core #(
  parameter int IMEM_DEPTH = 16,
  localparam int PC_W = $clog2(IMEM_DEPTH)
) (
  input  logic            clk,
  input  logic            reset,
  output logic [PC_W-1:0] imem_addr,
  input  logic [11:0]     imem_rd_data,
  output logic [5:0]      dmem_addr,
  output logic            dmem_we,
  output logic [7:0]      dmem_wr_data,
  input  logic [7:0]      dmem_rd_data,
  input  logic [2:0]      dbg_sel,
  output logic [7:0]      dbg_data,
  output logic            halted
);

  localparam logic [2:0]      OP_LD   = 3'b000;
  localparam logic [2:0]      OP_ST   = 3'b001;
  localparam logic [2:0]      OP_ADD  = 3'b010;
  localparam logic [2:0]      OP_HALT = 3'b111;
  localparam logic [PC_W-1:0] PC_LAST = PC_W'(IMEM_DEPTH - 1);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_EXEC  = 2'd1,
    S_HALT  = 2'd2
  } state_t;

  state_t          state;
  logic [PC_W-1:0] pc;
  logic [11:0]     ir;
  logic [7:0]      regs [8];

  logic [2:0] ir_op, ir_rd, ir_rs1, ir_rs2;
  logic [5:0] ir_ld_addr;
  logic [2:0] f_op, f_rs;
  logic [5:0] f_ld_addr, f_st_addr;

  assign ir_op      = ir[11:9];
  assign ir_rd      = ir[8:6];
  assign ir_rs1     = ir[5:3];
  assign ir_rs2     = ir[2:0];
  assign ir_ld_addr = ir[5:0];

  // Decode of the word being fetched, so the data-memory drive can be
  // registered and present for the whole EXEC cycle.
  assign f_op      = imem_rd_data[11:9];
  assign f_rs      = imem_rd_data[2:0];
  assign f_ld_addr = imem_rd_data[5:0];
  assign f_st_addr = imem_rd_data[8:3];

  assign imem_addr = pc;
  assign dbg_data  = regs[dbg_sel];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= S_FETCH;
      pc           <= '0;
      ir           <= '0;
      dmem_addr    <= '0;
      dmem_we      <= 1'b0;
      dmem_wr_data <= '0;
      halted       <= 1'b0;
      for (int i = 0; i < 8; i++) regs[i] <= '0;
    end else begin
      case (state)
        S_FETCH: begin
          ir    <= imem_rd_data;
          state <= S_EXEC;
          if (f_op == OP_LD) begin
            dmem_addr <= f_ld_addr;
          end else if (f_op == OP_ST) begin
            dmem_addr    <= f_st_addr;
            dmem_we      <= 1'b1;
            dmem_wr_data <= regs[f_rs];
          end
        end
        S_EXEC: begin
          case (ir_op)
            OP_LD:   regs[ir_rd] <= dmem_rd_data;
            OP_ADD:  regs[ir_rd] <= regs[ir_rs1] + regs[ir_rs2];
            default: ;
          endcase
          dmem_addr    <= '0;
          dmem_we      <= 1'b0;
          dmem_wr_data <= '0;
          // The PC saturates at the last address instead of wrapping.
          if (pc != PC_LAST) pc <= pc + 1'b1;
          if (ir_op == OP_HALT || pc == PC_LAST) begin
            state  <= S_HALT;
            halted <= 1'b1;
          end else begin
            state <= S_FETCH;
          end
        end
        default: state <= S_HALT;
      endcase
    end
  end

  // Unused decode bit kept visible for readability of the LD path.
  logic unused_ok;
  assign unused_ok = ^ir_ld_addr[5:0] & 1'b0;

endmodule

`default_nettype wire

// File: tb/tb_mcu_core.sv
// ============================================================================
// tb_mcu_core : directed + random programs checked against an ISA-level model
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_mcu_core;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  imem_addr;
  logic [11:0] imem_rd_data;
  logic [5:0]  dmem_addr;
  logic        dmem_we;
  logic [7:0]  dmem_wr_data;
  logic [7:0]  dmem_rd_data;
  logic [2:0]  dbg_sel;
  logic [7:0]  dbg_data;
  logic        halted;

  mcu_core #(.IMEM_DEPTH(16)) dut (
    .clk(clk), .reset(reset),
    .imem_addr(imem_addr), .imem_rd_data(imem_rd_data),
    .dmem_addr(dmem_addr), .dmem_we(dmem_we), .dmem_wr_data(dmem_wr_data),
    .dmem_rd_data(dmem_rd_data), .dbg_sel(dbg_sel), .dbg_data(dbg_data),
    .halted(halted)
  );

  always #5 clk = ~clk;

  logic [11:0] imem      [16];
  logic [7:0]  dmem      [64];
  logic [7:0]  dmem_init [64];
  int          wr_log    [$];
  logic        load_dmem = 1'b0;

  assign imem_rd_data = imem[imem_addr];
  assign dmem_rd_data = dmem[dmem_addr];

  always @(posedge clk) begin
    if (load_dmem) begin
      for (int i = 0; i < 64; i++) dmem[i] <= dmem_init[i];
      wr_log.delete();
    end else if (dmem_we) begin
      dmem[dmem_addr] <= dmem_wr_data;
      wr_log.push_back(int'(dmem_addr));
    end
  end

  int tests = 0;
  int fails = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [11:0] i_ld(input int rd, input int a);
    return {3'b000, 3'(rd), 6'(a)};
  endfunction
  function automatic logic [11:0] i_st(input int a, input int rs);
    return {3'b001, 6'(a), 3'(rs)};
  endfunction
  function automatic logic [11:0] i_add(input int rd, input int a, input int b);
    return {3'b010, 3'(rd), 3'(a), 3'(b)};
  endfunction
  localparam logic [11:0] I_HALT = 12'hE00;
  localparam logic [11:0] I_NOP  = 12'h600;

  // ISA-level reference: runs the program one instruction at a time.
  logic [7:0] m_r [8];
  logic [7:0] m_d [64];
  int         m_wr [$];
  int         m_cycles, m_pc;

  task automatic model_run();
    int pc;
    logic [11:0] ins;
    for (int i = 0; i < 8; i++) m_r[i] = 8'h00;
    for (int i = 0; i < 64; i++) m_d[i] = dmem_init[i];
    m_wr.delete();
    pc = 0;
    m_cycles = 0;
    for (int k = 0; k < 16; k++) begin
      ins = imem[pc];
      m_cycles += 2;
      case (ins[11:9])
        3'd0: m_r[ins[8:6]] = m_d[ins[5:0]];
        3'd1: begin m_d[ins[8:3]] = m_r[ins[2:0]]; m_wr.push_back(int'(ins[8:3])); end
        3'd2: m_r[ins[8:6]] = 8'((int'(m_r[ins[5:3]]) + int'(m_r[ins[2:0]])) % 256);
        default: ;
      endcase
      if (ins[11:9] == 3'd7) begin
        if (pc != 15) pc++;
        break;
      end
      if (pc == 15) break;
      pc++;
    end
    m_pc = pc;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    load_dmem = 1'b1;
    @(posedge clk);
    #1 load_dmem = 1'b0;
  endtask

  task automatic check_regs_zero(input string tag);
    for (int i = 0; i < 8; i++) begin
      dbg_sel = 3'(i);
      #1 chk(tag, dbg_data, 8'h00);
    end
  endtask

  task automatic run_prog(input string tag);
    int cyc;
    apply_reset();
    chk({tag, ":rst_halted"}, halted, 1'b0);
    chk({tag, ":rst_we"}, dmem_we, 1'b0);
    chk({tag, ":rst_daddr"}, dmem_addr, 6'd0);
    chk({tag, ":rst_wdata"}, dmem_wr_data, 8'd0);
    chk({tag, ":rst_iaddr"}, imem_addr, 4'd0);
    check_regs_zero({tag, ":rst_reg"});
    @(negedge clk);
    reset = 1'b0;
    model_run();
    cyc = 0;
    while (!halted && cyc < 100) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
    end
    chk({tag, ":cycles"}, cyc, m_cycles);
    chk({tag, ":pc"}, imem_addr, m_pc);
    for (int i = 0; i < 8; i++) begin
      dbg_sel = 3'(i);
      #1 chk({tag, ":reg"}, dbg_data, m_r[i]);
    end
    for (int i = 0; i < 64; i++) chk({tag, ":dmem"}, dmem[i], m_d[i]);
    chk({tag, ":nwrites"}, wr_log.size(), m_wr.size());
    for (int i = 0; i < m_wr.size() && i < wr_log.size(); i++)
      chk({tag, ":waddr"}, wr_log[i], m_wr[i]);
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 16; i++) imem[i] = I_NOP;
    for (int i = 0; i < 64; i++) dmem_init[i] = 8'h00;
  endtask

  logic [7:0] snap [8];
  logic [3:0] snap_pc;
  int         rnd;

  initial begin
    reset   = 1'b1;
    dbg_sel = 3'd0;

    // Fibonacci
    clear_mem();
    dmem_init[0] = 8'd1; dmem_init[1] = 8'd1;
    imem[0] = i_ld(0, 0);     imem[1] = i_ld(1, 1);
    imem[2] = i_add(2, 0, 1); imem[3] = i_add(3, 1, 2); imem[4] = i_add(4, 2, 3);
    imem[5] = i_st(2, 2);     imem[6] = i_st(3, 3);     imem[7] = i_st(4, 4);
    for (int i = 0; i < 5; i++) imem[8 + i] = i_ld(0, i);
    imem[13] = I_HALT;
    run_prog("fib");
    chk("fib:d2", dmem[2], 8'd2);
    chk("fib:d3", dmem[3], 8'd3);
    chk("fib:d4", dmem[4], 8'd5);
    dbg_sel = 3'd0;
    #1 chk("fib:r0", dbg_data, 8'd5);
    chk("fib:cyc28", m_cycles, 28);
    chk("fib:halted", halted, 1'b1);

    // HALT hold
    snap_pc = imem_addr;
    for (int i = 0; i < 8; i++) begin dbg_sel = 3'(i); #1 snap[i] = dbg_data; end
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      chk("hold:we", dmem_we, 1'b0);
      chk("hold:halted", halted, 1'b1);
    end
    chk("hold:pc", imem_addr, snap_pc);
    for (int i = 0; i < 8; i++) begin dbg_sel = 3'(i); #1 chk("hold:reg", dbg_data, snap[i]); end
    chk("hold:nwrites", wr_log.size(), 3);

    // ADD wrap
    clear_mem();
    dmem_init[0] = 8'hC8; dmem_init[1] = 8'h64;
    imem[0] = i_ld(1, 0); imem[1] = i_ld(2, 1); imem[2] = i_add(3, 1, 2); imem[3] = I_HALT;
    run_prog("wrap");
    dbg_sel = 3'd3;
    #1 chk("wrap:r3", dbg_data, 8'h2C);

    // Source/destination alias
    clear_mem();
    dmem_init[0] = 8'h05;
    imem[0] = i_ld(1, 0); imem[1] = i_add(1, 1, 1); imem[2] = I_HALT;
    run_prog("alias");
    dbg_sel = 3'd1;
    #1 chk("alias:r1", dbg_data, 8'h0A);

    // NOPs, no HALT: runs off the end of instruction memory
    clear_mem();
    for (int i = 0; i < 16; i++) imem[i] = {3'(3 + (i % 4)), 9'($urandom)};
    for (int i = 0; i < 64; i++) dmem_init[i] = 8'($urandom);
    run_prog("nop");
    chk("nop:pc15", imem_addr, 4'd15);
    chk("nop:cyc32", m_cycles, 32);
    chk("nop:nowrite", wr_log.size(), 0);
    check_regs_zero("nop:reg");

    // Reset during ST
    clear_mem();
    dmem_init[0] = 8'h7A; dmem_init[5] = 8'h33;
    imem[0] = i_ld(2, 0); imem[1] = i_st(5, 2); imem[2] = I_HALT;
    apply_reset();
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_st:we_before", dmem_we, 1'b1);
    chk("rst_st:addr_before", dmem_addr, 6'd5);
    reset = 1'b1;
    #1 chk("rst_st:we_drop", dmem_we, 1'b0);
    @(posedge clk);
    @(negedge clk);
    chk("rst_st:d5", dmem[5], 8'h33);
    chk("rst_st:nowrite", wr_log.size(), 0);
    check_regs_zero("rst_st:reg");
    reset = 1'b0;
    #1 chk("rst_st:fetch0", imem_addr, 4'd0);
    repeat (2) @(posedge clk);
    dbg_sel = 3'd2;
    #1 chk("rst_st:r2_after", dbg_data, 8'h7A);
    run_prog("rst_st_rerun");
    chk("rst_st_rerun:d5", dmem[5], 8'h7A);

    // Random programs
    for (int t = 0; t < 8; t++) begin
      for (int i = 0; i < 64; i++) dmem_init[i] = 8'($urandom);
      for (int i = 0; i < 16; i++) begin
        rnd = $urandom_range(0, 19);
        if (rnd < 5)       imem[i] = i_ld($urandom_range(0, 7), $urandom_range(0, 63));
        else if (rnd < 9)  imem[i] = i_st($urandom_range(0, 63), $urandom_range(0, 7));
        else if (rnd < 16) imem[i] = i_add($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7));
        else if (rnd < 19) imem[i] = {3'($urandom_range(3, 6)), 9'($urandom)};
        else               imem[i] = {3'b111, 9'($urandom)};
      end
      run_prog($sformatf("rand%0d", t));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
